// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 execution controller: opcodes, ALU operand selects,
// register load-enable bit positions and sequencer state encoding.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int unsigned LD_A   = 0;
  localparam int unsigned LD_B   = 1;
  localparam int unsigned LD_OUT = 2;
  localparam int unsigned LD_PC  = 3;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/td4_op_decode.sv
// Combinational TD4 instruction decode: opcode (+carry for JNC) to ALU operand
// select and register load enables. Unlisted opcodes decode as NOP.
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       carry_flag_i,
  output logic [1:0] select_o,
  output logic [3:0] load_o
);

  always_comb begin
    select_o = SEL_A;
    load_o   = 4'b0000;
    case (opcode_i)
      OP_ADD_A:  begin select_o = SEL_A;    load_o[LD_A]   = 1'b1; end
      OP_MOV_AB: begin select_o = SEL_B;    load_o[LD_A]   = 1'b1; end
      OP_IN_A:   begin select_o = SEL_IN;   load_o[LD_A]   = 1'b1; end
      OP_MOV_AI: begin select_o = SEL_ZERO; load_o[LD_A]   = 1'b1; end
      OP_MOV_BA: begin select_o = SEL_A;    load_o[LD_B]   = 1'b1; end
      OP_ADD_B:  begin select_o = SEL_B;    load_o[LD_B]   = 1'b1; end
      OP_IN_B:   begin select_o = SEL_IN;   load_o[LD_B]   = 1'b1; end
      OP_MOV_BI: begin select_o = SEL_ZERO; load_o[LD_B]   = 1'b1; end
      OP_OUT_B:  begin select_o = SEL_B;    load_o[LD_OUT] = 1'b1; end
      OP_OUT_I:  begin select_o = SEL_ZERO; load_o[LD_OUT] = 1'b1; end
      OP_JMP:    begin select_o = SEL_ZERO; load_o[LD_PC]  = 1'b1; end
      // JNC jumps only when the previous instruction produced no carry
      OP_JNC:    begin select_o = SEL_ZERO; load_o[LD_PC]  = ~carry_flag_i; end
      default:   begin select_o = SEL_A;    load_o         = 4'b0000; end
    endcase
  end

endmodule

// File: rtl/td4_exec_ctrl.sv
// TD4 multi-cycle sequencer (HALT/FETCH/EXEC) with run, halt and single-step
// debug control, a PC breakpoint and a retired-instruction counter.
module td4_exec_ctrl
  import td4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       pc,
  input  logic [3:0]       opcode,
  input  logic             carry_flag,
  output logic             ir_load,
  output logic [3:0]       load,
  output logic [1:0]       select,
  output logic             pc_inc,
  output logic             flag_load,
  output logic             halted,
  output logic             step_done,
  output logic [CNT_W-1:0] instr_count,
  output state_e           dbg_state
);

  state_e           state_q;
  logic             skip_bp_q;
  logic             single_q;
  logic             step_done_q;
  logic [CNT_W-1:0] count_q;

  logic [1:0] dec_select;
  logic [3:0] dec_load;
  logic       bp_hit;

  td4_op_decode u_decode (
    .opcode_i     (opcode),
    .carry_flag_i (carry_flag),
    .select_o     (dec_select),
    .load_o       (dec_load)
  );

  // skip_bp lets execution leave a breakpointed PC after a resume or step
  assign bp_hit = bp_en && (pc == bp_addr) && !skip_bp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HALT;
      skip_bp_q   <= 1'b0;
      single_q    <= 1'b0;
      step_done_q <= 1'b0;
      count_q     <= '0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (!halt_req) begin
            if (run) begin
              state_q   <= ST_FETCH;
              skip_bp_q <= 1'b1;
            end else if (step_req) begin
              state_q   <= ST_FETCH;
              skip_bp_q <= 1'b1;
              single_q  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (bp_hit) begin
            state_q <= ST_HALT;
          end else begin
            state_q   <= ST_EXEC;
            skip_bp_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          count_q <= count_q + 1'b1;
          if (single_q) begin
            state_q     <= ST_HALT;
            step_done_q <= 1'b1;
            single_q    <= 1'b0;
          end else if (halt_req || !run) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  // Strobes are decoded from the state register; reset masks them so an
  // instruction interrupted by reset performs no writes.
  always_comb begin
    ir_load   = 1'b0;
    load      = 4'b0000;
    select    = SEL_A;
    pc_inc    = 1'b0;
    flag_load = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_HALT:  halted  = 1'b1;
      ST_FETCH: ir_load = !bp_hit;
      ST_EXEC: begin
        load      = dec_load;
        select    = dec_select;
        flag_load = 1'b1;
        pc_inc    = ~dec_load[LD_PC];
      end
      default: halted = 1'b1;
    endcase
    if (reset) begin
      ir_load   = 1'b0;
      load      = 4'b0000;
      pc_inc    = 1'b0;
      flag_load = 1'b0;
    end
  end

  assign step_done   = step_done_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule
